adc_spi_sampler: RTL and testbench

//   Upstream feeder for the APB ADC read-back slave. Drives a 12-bit serial SPI ADC
//     (AD7476-style frame: 16 SCLK, 4 leading zeros, then 12 data bits MSB first).

---
 rtl/adc_spi_sampler.sv | 196 +++++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler.sv
// Periodic sampler for an AD7476-style 12-bit SPI ADC: paces conversions, clocks out
// one 16-bit frame per conversion and publishes the 12-bit result with a one-cycle valid.
`timescale 1ns/1ps

module adc_spi_sampler #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000,
   parameter int QUIET_CYCLES  = 8
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        sample_enable,
   input  logic        adc_sdo,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [11:0] adc_data,
   output logic        adc_valid,
   output logic        adc_frame_err,
   output logic        adc_busy
);

   localparam int DIV_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
   localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam int PER_W   = $clog2(SAMPLE_PERIOD);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
      S_DONE,
      S_QUIET
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_div_cnt;
   logic [3:0]         r_bit_cnt;
   logic [15:0]        r_shift;
   logic [PER_W-1:0]   r_per_cnt;
   logic               r_en_d;
   logic               r_start_pend;
   logic               r_cs_n;
   logic               r_sclk;
   logic [11:0]        r_data;
   logic               r_valid;
   logic               r_frame_err;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_div_nxt;
   logic [3:0]         w_bit_nxt;
   logic               w_cs_n_nxt;
   logic               w_sclk_nxt;
   logic               w_sample;
   logic               w_done;
   logic               w_start;
   logic               w_per_wrap;
   logic               w_pend_set;

   // The first enabled edge counts as phase 0 of the period, so it raises a pend itself.
   assign w_per_wrap = (r_per_cnt == PER_LAST);
   assign w_pend_set = sample_enable && (!r_en_d || w_per_wrap);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_en_d       <= 1'b0;
         r_per_cnt    <= '0;
         r_start_pend <= 1'b0;
      end else begin
         // NOTE: all clocked state uses non-blocking assignments so every flop samples
         // pre-edge values regardless of the order the always blocks are evaluated in.
         r_en_d <= sample_enable;
         if (!sample_enable || !r_en_d || w_per_wrap) begin
            r_per_cnt <= '0;
         end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
         end
         r_start_pend <= (r_start_pend && !w_start) || w_pend_set;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path through the
      // case statement can leave a signal unassigned and infer a latch.
      w_state_nxt = r_state;
      w_div_nxt   = r_div_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_cs_n_nxt  = r_cs_n;
      w_sclk_nxt  = r_sclk;
      w_sample    = 1'b0;
      w_done      = 1'b0;
      w_start     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cs_n_nxt = 1'b1;
            w_sclk_nxt = 1'b1;
            if (r_start_pend && sample_enable) begin
               w_state_nxt = S_START;
               w_start     = 1'b1;
               w_div_nxt   = '0;
               w_cs_n_nxt  = 1'b0;
            end
         end
         S_START: begin
            if (r_div_cnt == DIV_LAST) begin
               w_state_nxt = S_SHIFT;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_sclk_nxt  = 1'b0;
            end else begin
               w_div_nxt = r_div_cnt + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            // r_sclk doubles as the half-slot indicator: low half, then high half.
            if (r_div_cnt == DIV_LAST) begin
               w_div_nxt = '0;
               if (!r_sclk) begin
                  w_sclk_nxt = 1'b1;
                  w_sample   = 1'b1;
               end else if (r_bit_cnt == 4'd15) begin
                  w_state_nxt = S_DONE;
                  w_done      = 1'b1;
                  w_cs_n_nxt  = 1'b1;
               end else begin
                  w_bit_nxt  = r_bit_cnt + 4'd1;
                  w_sclk_nxt = 1'b0;
               end
            end else begin
               w_div_nxt = r_div_cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_QUIET;
            w_div_nxt   = '0;
         end
         S_QUIET: begin
            if (r_div_cnt == QUIET_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_div_nxt = r_div_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cs_n_nxt  = 1'b1;
            w_sclk_nxt  = 1'b1;
         end
      endcase
   end

   // cs_n and sclk are registered from next-state values so the pins never glitch.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         // NOTE: the shift register is reset along with the control flops; it is small
         // and a known value keeps a discarded frame from leaking into the next one.
         r_state     <= S_IDLE;
         r_div_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_cs_n      <= 1'b1;
         r_sclk      <= 1'b1;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_div_cnt   <= w_div_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_cs_n      <= w_cs_n_nxt;
         r_sclk      <= w_sclk_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_valid     <= w_done;
         r_frame_err <= w_done && (r_shift[15:12] != 4'd0);
         if (w_sample) begin
            r_shift <= {r_shift[14:0], adc_sdo};
         end
         if (w_done) begin
            r_data <= r_shift[11:0];
         end
      end
   end

   assign adc_cs_n      = r_cs_n;
   assign adc_sclk      = r_sclk;
   assign adc_data      = r_data;
   assign adc_valid     = r_valid;
   assign adc_frame_err = r_frame_err;
   assign adc_busy      = r_busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench for adc_spi_sampler: an ADC serial model plus a frame-timeline
// reference model compared against the DUT every cycle, with directed and random phases.
`timescale 1ns/1ps

module tb_adc_spi_sampler;

   localparam int D  = 4;
   localparam int Q  = 8;
   localparam int SP = 200;
   localparam int SP_FAST   = 50;
   localparam int VALID_AT  = 33 * D;            // offset of the valid cycle from START
   localparam int IDLE_AT   = 33 * D + 1 + Q;    // first offset that is back in IDLE
   localparam int MIN_SPACE = 33 * D + 1 + Q + 1;

   logic        PCLK;
   logic        PRESETn;
   logic        sample_enable;
   logic        adc_sdo;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic [11:0] adc_data;
   logic        adc_valid;
   logic        adc_frame_err;
   logic        adc_busy;

   logic        f_cs_n;
   logic        f_sclk;
   logic [11:0] f_data;
   logic        f_valid;
   logic        f_frame_err;
   logic        f_busy;

   adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .QUIET_CYCLES(Q)) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .sample_enable (sample_enable),
      .adc_sdo       (adc_sdo),
      .adc_cs_n      (adc_cs_n),
      .adc_sclk      (adc_sclk),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .adc_frame_err (adc_frame_err),
      .adc_busy      (adc_busy)
   );

   // Second instance with a period shorter than one frame: spacing only.
   adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP_FAST), .QUIET_CYCLES(Q)) dut_fast (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .sample_enable (sample_enable),
      .adc_sdo       (adc_sdo),
      .adc_cs_n      (f_cs_n),
      .adc_sclk      (f_sclk),
      .adc_data      (f_data),
      .adc_valid     (f_valid),
      .adc_frame_err (f_frame_err),
      .adc_busy      (f_busy)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- ADC serial model ----------------
   logic [15:0] word_q[$];
   logic [15:0] cur_word = 16'h0;
   int          fall_cnt = 0;
   int          rise_cnt = 0;

   always @(negedge adc_cs_n) begin
      logic [31:0] r;
      if (word_q.size() > 0) begin
         cur_word = word_q.pop_front();
      end else begin
         r = $urandom;
         if ($urandom_range(0, 3) != 0) r[15:12] = 4'h0;
         cur_word = r[15:0];
      end
      fall_cnt = 0;
      rise_cnt = 0;
   end

   // ADC shifts a new bit out on each falling SCLK edge, MSB first.
   always @(negedge adc_sclk) begin
      if (!adc_cs_n && fall_cnt < 16) begin
         adc_sdo = cur_word[15 - fall_cnt];
         fall_cnt++;
      end
   end

   always @(posedge adc_sclk) begin
      if (!adc_cs_n) rise_cnt++;
   end

   // ---------------- reference model: frame timeline ----------------
   int          m_n, m_s, m_age;
   logic        m_pend, m_en_d, m_err;
   logic [11:0] m_data;
   logic        w_idle, w_go, w_set;
   int          w_age_nxt;

   always_comb begin
      w_idle    = (m_s < 0) || (m_n - m_s >= IDLE_AT);
      w_go      = w_idle && m_pend && sample_enable;
      w_age_nxt = m_en_d ? m_age + 1 : 0;
      w_set     = sample_enable && ((w_age_nxt % SP) == 0);
   end

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_n    <= 0;
         m_s    <= -1;
         m_age  <= 0;
         m_pend <= 1'b0;
         m_en_d <= 1'b0;
         m_err  <= 1'b0;
         m_data <= 12'h0;
      end else begin
         m_n    <= m_n + 1;
         m_en_d <= sample_enable;
         m_age  <= w_age_nxt;
         m_pend <= (m_pend && !w_go) || w_set;
         if (w_go) m_s <= m_n + 1;
         if (m_s >= 0 && (m_n + 1 - m_s) == VALID_AT) begin
            m_data <= cur_word[11:0];
            m_err  <= |cur_word[15:12];
         end
      end
   end

   // ---------------- per-cycle comparison and event log ----------------
   int          cyc = 0;
   int          valid_cnt = 0;
   int          falls_q[$];
   int          fast_falls_q[$];
   int          vcyc_q[$];
   int          vrise_q[$];
   logic [11:0] vdata_q[$];
   logic        verr_q[$];
   logic        prev_cs = 1'b1;
   logic        prev_fcs = 1'b1;

   always @(negedge PCLK) begin
      int   k;
      logic act, e_busy, e_cs_low, e_sclk, e_valid;
      cyc++;
      k        = m_n - m_s;
      act      = (m_s >= 0);
      e_busy   = act && (k < IDLE_AT);
      e_cs_low = act && (k < VALID_AT);
      e_sclk   = !(e_cs_low && k >= D && ((k - D) % (2 * D)) < D);
      e_valid  = act && (k == VALID_AT);
      check("cs_n",  32'(adc_cs_n),      32'(!e_cs_low));
      check("sclk",  32'(adc_sclk),      32'(e_sclk));
      check("busy",  32'(adc_busy),      32'(e_busy));
      check("valid", 32'(adc_valid),     32'(e_valid));
      check("err",   32'(adc_frame_err), 32'(e_valid && m_err));
      check("data",  32'(adc_data),      32'(m_data));
      if (prev_cs && !adc_cs_n) falls_q.push_back(cyc);
      if (prev_fcs && !f_cs_n) fast_falls_q.push_back(cyc);
      prev_cs  = adc_cs_n;
      prev_fcs = f_cs_n;
      if (adc_valid) begin
         valid_cnt++;
         vcyc_q.push_back(cyc);
         vrise_q.push_back(rise_cnt);
         vdata_q.push_back(adc_data);
         verr_q.push_back(adc_frame_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge PCLK);
      #1;
   endtask

   task automatic clear_log();
      valid_cnt = 0;
      falls_q.delete();
      fast_falls_q.delete();
      vcyc_q.delete();
      vrise_q.delete();
      vdata_q.delete();
      verr_q.delete();
   endtask

   task automatic wait_slot(input int falls, input string tag);
      int i;
      for (i = 0; i < 600 && !(!adc_cs_n && fall_cnt == falls); i++) tick(1);
      check(tag, 32'(!adc_cs_n && fall_cnt == falls), 32'd1);
   endtask

   logic [15:0] t1_words[4];
   int          en_cyc;

   initial begin
      t1_words      = '{16'h0A5C, 16'h0FFF, 16'h0000, 16'h8123};
      PRESETn       = 1'b0;
      sample_enable = 1'b0;
      adc_sdo       = 1'b0;
      tick(5);
      check("rst_cs_n",  32'(adc_cs_n),      32'd1);
      check("rst_sclk",  32'(adc_sclk),      32'd1);
      check("rst_data",  32'(adc_data),      32'd0);
      check("rst_valid", 32'(adc_valid),     32'd0);
      check("rst_err",   32'(adc_frame_err), 32'd0);
      check("rst_busy",  32'(adc_busy),      32'd0);
      PRESETn = 1'b1;
      tick(3);

      // Directed frames and pacing over exactly 1000 enabled cycles.
      clear_log();
      for (int i = 0; i < 4; i++) word_q.push_back(t1_words[i]);
      en_cyc        = cyc;
      sample_enable = 1'b1;
      tick(1000);
      sample_enable = 1'b0;
      tick(200);
      check("t1_valid_count", 32'(valid_cnt), 32'd5);
      check("t1_fall_count",  32'(falls_q.size()), 32'd5);
      if (vcyc_q.size() > 0) check("t1_latency", 32'(vcyc_q[0] - en_cyc), 32'(2 + 33 * D));
      for (int i = 0; i < 4 && i < vdata_q.size(); i++) begin
         check("t1_data", 32'(vdata_q[i]), 32'(t1_words[i][11:0]));
         check("t1_err",  32'(verr_q[i]),  32'(|t1_words[i][15:12]));
      end
      for (int i = 0; i < vrise_q.size(); i++) check("t1_sclk_rises", 32'(vrise_q[i]), 32'd16);
      for (int i = 1; i < falls_q.size(); i++)
         check("t1_spacing", 32'(falls_q[i] - falls_q[i-1]), 32'(SP));
      check("fast_fall_count_ge2", 32'(fast_falls_q.size() >= 2), 32'd1);
      for (int i = 1; i < fast_falls_q.size(); i++)
         check("fast_spacing", 32'(fast_falls_q[i] - fast_falls_q[i-1]), 32'(MIN_SPACE));

      // Enable dropped during bit slot 6: the frame still completes.
      clear_log();
      sample_enable = 1'b1;
      wait_slot(7, "t5_reach_slot6");
      sample_enable = 1'b0;
      tick(300);
      check("t5_valid_count", 32'(valid_cnt), 32'd1);
      check("t5_cs_n_idle",   32'(adc_cs_n),  32'd1);
      check("t5_busy_idle",   32'(adc_busy),  32'd0);

      // Reset during bit slot 9: frame discarded, nothing until re-enabled.
      clear_log();
      sample_enable = 1'b1;
      wait_slot(10, "t6_reach_slot9");
      PRESETn = 1'b0;
      #1;
      check("t6_cs_n",  32'(adc_cs_n),  32'd1);
      check("t6_sclk",  32'(adc_sclk),  32'd1);
      check("t6_data",  32'(adc_data),  32'd0);
      check("t6_valid", 32'(adc_valid), 32'd0);
      sample_enable = 1'b0;
      tick(3);
      PRESETn = 1'b1;
      tick(300);
      check("t6_no_valid", 32'(valid_cnt), 32'd0);
      sample_enable = 1'b1;
      tick(200);
      check("t6_reenable_valid", 32'(valid_cnt), 32'd1);
      sample_enable = 1'b0;
      tick(200);

      // Random enable pattern with random ADC words; the per-cycle model checks it all.
      for (int i = 0; i < 14; i++) begin
         sample_enable = 1'($urandom_range(0, 1));
         tick($urandom_range(20, 700));
      end
      sample_enable = 1'b0;
      tick(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
